weather_alert_responder: RTL
============================

Name: weather_alert_responder

Overview:
- Consumer end of the environmental control/weather unit's alert interface.
- Takes severe_weather, emergency_landing_alert and the 2-bit weather state code, filters them, and drives cockpit annunciation (lamps, horn).
- Runs a pilot-acknowledge handshake and a landing-request/grant handshake with the runway allocation unit.
- Sits between the weather unit and the cockpit/ATC interfaces; fully synchronous to CLK.

Parameters:
- STABLE_CYCLES, 2: consecutive identical samples needed to accept a non-emergency level change (min 1).
- ACK_TIMEOUT, 8: cycles in WARN without pilot_ack before ack_overdue asserts.
- GRANT_TIMEOUT, 16: cycles in EMERG without runway_grant before divert_advisory asserts.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- severe_weather  in  1  severe flag from the weather unit.
- emergency_landing_alert  in  1  emergency flag from the weather unit.
- wx_state  in  2  weather unit state code: 0 normal, 1 caution, 2 severe, 3 emergency.
- pilot_ack  in  1  single-cycle or level acknowledge from the cockpit.
- runway_grant  in  1  landing grant from the runway allocator.
- caution_lamp  out  1  caution annunciator.
- warning_lamp  out  1  warning annunciator.
- horn  out  1  audible alarm.
- ack_overdue  out  1  pilot failed to acknowledge within ACK_TIMEOUT.
- landing_request  out  1  request to the runway allocator.
- landing_clear  out  1  landing granted (terminal).
- divert_advisory  out  1  grant timed out at least once (sticky).
- resp_state  out  3  FSM state code, for debug.

Behaviour:
- Effective level, combinational: eff = 3 if emergency_landing_alert; else 2 if severe_weather or wx_state>=2; else 1 if wx_state==1; else 0.
- Sampling: eff is registered into samp on every posedge.
- Filter: a candidate/count pair tracks samp. A differing samp loads cand=samp, cnt=1; an equal samp increments cnt, saturating. lvl takes cand when cnt==STABLE_CYCLES.
- Filter latency: eff changed and held before edge n gives the new FSM state after edge n+STABLE_CYCLES.
- Emergency bypass: samp==3 at edge n puts the FSM in EMERG after edge n+1, with no filtering.
- FSM states (resp_state): NORMAL=0, CAUTION=1, WARN=2, WARN_ACK=3, EMERG=4, LANDING=5.
  - From NORMAL, CAUTION, WARN, WARN_ACK: lvl 0→NORMAL, 1→CAUTION, 2→WARN; from WARN_ACK, lvl 2 holds WARN_ACK (no re-horn).
  - WARN + pilot_ack → WARN_ACK. pilot_ack is ignored in all other states.
  - Any state except LANDING: emergency (bypass) → EMERG.
  - EMERG and LANDING ignore lower levels. Only RST exits them.
  - EMERG + runway_grant → LANDING.
  - LANDING is terminal.
- Outputs are decoded from the state register:
  - caution_lamp = CAUTION | WARN | WARN_ACK.
  - warning_lamp = WARN | WARN_ACK | EMERG | LANDING.
  - horn = WARN | EMERG.
  - landing_request = EMERG.
  - landing_clear = LANDING.
- Ack timer: ack_cnt clears on entry to WARN and counts each cycle spent in WARN.
  - ack_overdue sets when ack_cnt reaches ACK_TIMEOUT.
  - It stays set while in WARN and clears on leaving WARN.
- Grant timer: grant_cnt counts each cycle in EMERG.
  - At GRANT_TIMEOUT, divert_advisory sets and grant_cnt reloads to 0; landing_request stays high and the retry continues.
  - divert_advisory is sticky until RST.
- Simultaneous events:
  - Emergency beats pilot_ack and beats any level change.
  - runway_grant in the same cycle as grant timeout: the grant wins → LANDING, and divert_advisory is not set by that cycle.
  - pilot_ack in the same cycle as ack timeout: the ack wins → WARN_ACK, ack_overdue stays 0.
- Reset: RST asynchronously clears samp, cand, cnt, lvl, all counters and the FSM (→NORMAL). All outputs read 0, resp_state=0. Reset mid-EMERG or mid-LANDING also clears to NORMAL.
- Widths: counters are sized to clog2 of the parameter +1 and never wrap. wx_state is treated as unsigned.

Test Plan:
- Reset mid-operation: hold emergency_landing_alert=1 to reach EMERG, then pulse RST asynchronously between edges → all outputs 0, resp_state=0 immediately, with no dependence on CLK.
- Caution filter: wx_state=1 for a single cycle, then 0 → no state change. wx_state=1 held → CAUTION after STABLE_CYCLES+1 edges (edge 3 with default 2), caution_lamp=1, horn=0.
- Warn/ack: severe_weather=1 held → WARN with horn=1, warning_lamp=1. pilot_ack at cycle 5 → WARN_ACK, horn=0, lamps stay on. Repeat with no ack → ack_overdue=1 at the 8th WARN cycle.
- Emergency bypass: in CAUTION, raise emergency_landing_alert → EMERG after 2 edges, landing_request=1, horn=1. Then drop all weather inputs to 0 → remains EMERG.
- Grant timeout and grant:
  - In EMERG, no runway_grant for 16 cycles → divert_advisory=1, landing_request still 1.
  - runway_grant at cycle 20 → LANDING, landing_clear=1, horn=0, landing_request=0.
  - Separately: runway_grant exactly on the 16th cycle → LANDING with divert_advisory=0.
- Priority: in WARN, emergency and pilot_ack asserted in the same cycle → EMERG, and WARN_ACK is never entered.

Source files
------------

// File: rtl/weather_alert_responder.sv
// Weather alert responder: filters weather-unit alert levels and drives cockpit
// annunciation plus the pilot-acknowledge and runway landing-request handshakes.
module weather_alert_responder #(
    parameter int STABLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 8,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       severe_weather,
    input  logic       emergency_landing_alert,
    input  logic [1:0] wx_state,
    input  logic       pilot_ack,
    input  logic       runway_grant,
    output logic       caution_lamp,
    output logic       warning_lamp,
    output logic       horn,
    output logic       ack_overdue,
    output logic       landing_request,
    output logic       landing_clear,
    output logic       divert_advisory,
    output logic [2:0] resp_state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        CAUTION  = 3'd1,
        WARN     = 3'd2,
        WARN_ACK = 3'd3,
        EMERG    = 3'd4,
        LANDING  = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [1:0]    eff, samp, cand, lvl;
    logic [1:0]    cand_next, lvl_next;
    logic [SW-1:0] cnt, cnt_next;
    logic [AW-1:0] ack_cnt;
    logic [GW-1:0] grant_cnt;
    logic          emerg, ack_ok;

    always_comb begin
        eff = 2'd0;
        if (emergency_landing_alert)
            eff = 2'd3;
        else if (severe_weather || (wx_state >= 2'd2))
            eff = 2'd2;
        else if (wx_state == 2'd1)
            eff = 2'd1;
    end

    // The accepted level is taken from the filter's next values so a level
    // held STABLE_CYCLES samples reaches the FSM on that same edge.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (samp != cand) begin
            cand_next = samp;
            cnt_next  = SW'(1);
        end else if (cnt != SW'(STABLE_CYCLES)) begin
            cnt_next = cnt + SW'(1);
        end
        lvl_next = (cnt_next == SW'(STABLE_CYCLES)) ? cand_next : lvl;
    end

    // An emergency already on the raw inputs also suppresses a pending acknowledge.
    assign emerg  = (samp == 2'd3);
    assign ack_ok = pilot_ack && !emerg && (eff != 2'd3);

    always_comb begin
        state_next = state;
        case (state)
            LANDING: state_next = LANDING;
            EMERG:   if (runway_grant) state_next = LANDING;
            default: begin
                if (emerg) begin
                    state_next = EMERG;
                end else begin
                    case (lvl_next)
                        2'd0: state_next = NORMAL;
                        2'd1: state_next = CAUTION;
                        2'd2: begin
                            if (state == WARN_ACK || (state == WARN && ack_ok))
                                state_next = WARN_ACK;
                            else
                                state_next = WARN;
                        end
                        default: state_next = state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp  <= 2'd0;
            cand  <= 2'd0;
            cnt   <= '0;
            lvl   <= 2'd0;
            state <= NORMAL;
        end else begin
            samp  <= eff;
            cand  <= cand_next;
            cnt   <= cnt_next;
            lvl   <= lvl_next;
            state <= state_next;
        end
    end

    // Timers only advance on edges where the FSM stays put, so a grant or ack
    // on the timeout edge leaves the state and never raises the flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_cnt     <= '0;
            ack_overdue <= 1'b0;
        end else if (state == WARN && state_next == WARN) begin
            if (ack_cnt != AW'(ACK_TIMEOUT))
                ack_cnt <= ack_cnt + AW'(1);
            if (ack_cnt == AW'(ACK_TIMEOUT - 1))
                ack_overdue <= 1'b1;
        end else begin
            ack_cnt     <= '0;
            ack_overdue <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt       <= '0;
            divert_advisory <= 1'b0;
        end else if (state == EMERG && state_next == EMERG) begin
            if (grant_cnt == GW'(GRANT_TIMEOUT - 1)) begin
                grant_cnt       <= '0;
                divert_advisory <= 1'b1;
            end else begin
                grant_cnt <= grant_cnt + GW'(1);
            end
        end else begin
            grant_cnt <= '0;
        end
    end

    assign caution_lamp    = (state == CAUTION) || (state == WARN) || (state == WARN_ACK);
    assign warning_lamp    = (state == WARN) || (state == WARN_ACK) || (state == EMERG) || (state == LANDING);
    assign horn            = (state == WARN) || (state == EMERG);
    assign landing_request = (state == EMERG);
    assign landing_clear   = (state == LANDING);
    assign resp_state      = state;

endmodule
